// File: rtl/alu_types_pkg.sv
// Shared types for the pipelined ALU: opcode encoding and default geometry.
package alu_types;

   typedef enum logic [2:0] {
      ADD = 3'd0,
      SUB = 3'd1,
      AND = 3'd2,
      OR  = 3'd3,
      XOR = 3'd4,
      SHL = 3'd5,
      SHR = 3'd6,
      MUL = 3'd7
   } operation_t;

   localparam int DEF_WIDTH  = 6;
   localparam int DEF_STAGES = 2;
   localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath feeding pipeline stage 0; zero latency, no flow control.
// ALU_MUL_EN selects a real multiplier; otherwise MUL returns 0 with the error flag set.
module alu_core
   import alu_types::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  operation_t       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH:0]   res,
   output logic             err
);

   logic [WIDTH:0] ax;
   logic [WIDTH:0] bx;

   assign ax = {1'b0, a};
   assign bx = {1'b0, b};

`ifdef ALU_MUL_EN
   logic [2*WIDTH-1:0] prod;
   assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif

   always_comb begin
      res = '0;
      err = 1'b0;
      case (op)
         ADD: res = ax + bx;
         SUB: res = ax - bx;   // MSB doubles as borrow
         AND: res = ax & bx;
         OR:  res = ax | bx;
         XOR: res = ax ^ bx;
         SHL: res = ax << b;
         SHR: res = ax >> b;
         MUL: begin
`ifdef ALU_MUL_EN
            res = prod[WIDTH:0];
            err = |prod[2*WIDTH-1:WIDTH+1];
`else
            res = '0;
            err = 1'b1;
`endif
         end
         default: begin
            res = '0;
            err = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU, fixed latency STAGES cycles; whole pipe stalls while out_valid && !out_ready.
// Optional multiplier enabled by ALU_MUL_EN (see alu_core).
module alu_pipe
   import alu_types::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  operation_t       op_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH:0]   out,
   output logic             out_err,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] ops_cnt
);

   typedef struct packed {
      logic           valid;
      logic [WIDTH:0] out;
      logic           err;
   } alu_stage_t;

   alu_stage_t     stg [STAGES];
   logic [WIDTH:0] core_res;
   logic           core_err;
   logic           en;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .op  (op_in),
      .a   (a_in),
      .b   (b_in),
      .res (core_res),
      .err (core_err)
   );

   assign en        = !out_valid || out_ready;
   assign in_ready  = en;
   assign out       = stg[STAGES-1].out;
   assign out_err   = stg[STAGES-1].err;
   assign out_valid = stg[STAGES-1].valid;

   // Payload only moves with a valid token, so bubbles leave the last result in place.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            stg[i] <= '0;
         end
         ops_cnt <= '0;
      end else begin
         if (out_valid && out_ready) begin
            ops_cnt <= ops_cnt + CNT_W'(1);
         end
         if (en) begin
            stg[0].valid <= in_valid;
            if (in_valid) begin
               stg[0].out <= core_res;
               stg[0].err <= core_err;
            end
            for (int i = 1; i < STAGES; i++) begin
               stg[i].valid <= stg[i-1].valid;
               if (stg[i-1].valid) begin
                  stg[i].out <= stg[i-1].out;
                  stg[i].err <= stg[i-1].err;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe at WIDTH=6, STAGES=2.
module tb_alu_pipe;
   import alu_types::*;

   localparam int WIDTH  = 6;
   localparam int STAGES = 2;
   localparam int CNT_W  = 16;

   logic             clk = 1'b0;
   logic             rst;
   operation_t       op_in;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH:0]   out;
   logic             out_err;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] ops_cnt;

   int n_cmp = 0;
   int n_err = 0;

   alu_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .op_in     (op_in),
      .a_in      (a_in),
      .b_in      (b_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out       (out),
      .out_err   (out_err),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ops_cnt   (ops_cnt)
   );

   always #5 clk = ~clk;

   // Drives one request with out_ready high and waits for its result; lat counts negedges after accept.
   task automatic do_op(input operation_t op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        output logic [WIDTH:0] res, output logic err, output int lat);
      @(negedge clk);
      op_in = op; a_in = a; b_in = b; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0; res = '0; err = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = k; res = out; err = out_err;
            break;
         end
      end
      if (lat == 0) begin
         n_cmp++; n_err++;
         $display("FAIL timeout op=%0d: out_valid never rose, required within 10 cycles", op);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      op_in = ADD; a_in = '0; b_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_cmp++; if (out !== 7'd0) begin n_err++; $display("FAIL reset_out got %0d want 0", out); end
      n_cmp++; if (out_err !== 1'b0) begin n_err++; $display("FAIL reset_out_err got %b want 0", out_err); end
      n_cmp++; if (ops_cnt !== 16'd0) begin n_err++; $display("FAIL reset_ops_cnt got %0d want 0", ops_cnt); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      rst = 1'b0;
   endtask

   task automatic test_add;
      logic [WIDTH:0] r; logic e; int lat;
      do_op(ADD, 6'd63, 6'd63, r, e, lat);
      n_cmp++; if (r !== 7'd126) begin n_err++; $display("FAIL add_63_63 got %0d want 126", r); end
      n_cmp++; if (e !== 1'b0) begin n_err++; $display("FAIL add_err got %b want 0", e); end
      n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL add_latency got %0d want 2", lat); end
      @(negedge clk);
      n_cmp++; if (ops_cnt !== 16'd1) begin n_err++; $display("FAIL add_ops_cnt got %0d want 1", ops_cnt); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_drained got %b want 0", out_valid); end
   endtask

   task automatic test_sub_logic;
      logic [WIDTH:0] r; logic e; int lat;
      do_op(SUB, 6'd5, 6'd9, r, e, lat);
      n_cmp++; if (r !== 7'h7C || e !== 1'b0) begin n_err++; $display("FAIL sub_5_9 got %0d/%b want 124/0", r, e); end
      do_op(AND, 6'h2A, 6'h0F, r, e, lat);
      n_cmp++; if (r !== 7'd10 || e !== 1'b0) begin n_err++; $display("FAIL and got %0d/%b want 10/0", r, e); end
      do_op(OR, 6'h2A, 6'h15, r, e, lat);
      n_cmp++; if (r !== 7'd63 || e !== 1'b0) begin n_err++; $display("FAIL or got %0d/%b want 63/0", r, e); end
      do_op(XOR, 6'h3F, 6'h0F, r, e, lat);
      n_cmp++; if (r !== 7'd48 || e !== 1'b0) begin n_err++; $display("FAIL xor got %0d/%b want 48/0", r, e); end
   endtask

   task automatic test_shift;
      logic [WIDTH:0] r; logic e; int lat;
      do_op(SHL, 6'h21, 6'd1, r, e, lat);
      n_cmp++; if (r !== 7'd66 || e !== 1'b0) begin n_err++; $display("FAIL shl_21_1 got %0d/%b want 66/0", r, e); end
      do_op(SHL, 6'h21, 6'd7, r, e, lat);
      n_cmp++; if (r !== 7'd0 || e !== 1'b0) begin n_err++; $display("FAIL shl_21_7 got %0d/%b want 0/0", r, e); end
      do_op(SHL, 6'h3F, 6'd1, r, e, lat);
      n_cmp++; if (r !== 7'd126) begin n_err++; $display("FAIL shl_3f_1 got %0d want 126", r); end
      do_op(SHR, 6'h3F, 6'd6, r, e, lat);
      n_cmp++; if (r !== 7'd0 || e !== 1'b0) begin n_err++; $display("FAIL shr_3f_6 got %0d/%b want 0/0", r, e); end
      do_op(SHR, 6'h3F, 6'd2, r, e, lat);
      n_cmp++; if (r !== 7'd15) begin n_err++; $display("FAIL shr_3f_2 got %0d want 15", r); end
   endtask

   task automatic test_mul;
      logic [WIDTH:0] r; logic e; int lat;
`ifdef ALU_MUL_EN
      do_op(MUL, 6'd9, 6'd9, r, e, lat);
      n_cmp++; if (r !== 7'd81 || e !== 1'b0) begin n_err++; $display("FAIL mul_9_9 got %0d/%b want 81/0", r, e); end
      do_op(MUL, 6'd12, 6'd12, r, e, lat);
      n_cmp++; if (r !== 7'd16 || e !== 1'b1) begin n_err++; $display("FAIL mul_12_12 got %0d/%b want 16/1", r, e); end
`else
      do_op(MUL, 6'd9, 6'd9, r, e, lat);
      n_cmp++; if (r !== 7'd0 || e !== 1'b1) begin n_err++; $display("FAIL mul_off_9_9 got %0d/%b want 0/1", r, e); end
`endif
      // Error flag must not leak into a following non-MUL op
      do_op(ADD, 6'd1, 6'd2, r, e, lat);
      n_cmp++; if (r !== 7'd3 || e !== 1'b0) begin n_err++; $display("FAIL add_after_mul got %0d/%b want 3/0", r, e); end
   endtask

   task automatic test_back_to_back;
      logic [WIDTH-1:0] va [4] = '{6'd1, 6'd10, 6'd40, 6'd63};
      logic [WIDTH-1:0] vb [4] = '{6'd2, 6'd20, 6'd1, 6'd0};
      logic [WIDTH:0]   exp [4] = '{7'd3, 7'd30, 7'd41, 7'd63};
      logic [WIDTH:0]   got [$];
      logic [WIDTH:0]   held;
      logic             prev_stall;
      int               sent;
      rst = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      sent = 0; prev_stall = 1'b0; held = '0;
      for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
         @(negedge clk);
         out_ready = !(cyc >= 3 && cyc < 6);
         #1;
         if (out_valid && !out_ready) begin
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_in_ready_stall cyc %0d got %b want 0", cyc, in_ready); end
            if (prev_stall) begin
               n_cmp++; if (out !== held) begin n_err++; $display("FAIL b2b_out_stable cyc %0d got %0d want %0d", cyc, out, held); end
            end
            held = out;
         end
         prev_stall = out_valid && !out_ready;
         if (out_valid && out_ready) got.push_back(out);
         if (in_ready && sent < 4) begin
            op_in = ADD; a_in = va[sent]; b_in = vb[sent]; in_valid = 1'b1;
            sent++;
         end else begin
            in_valid = 1'b0;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++; if (got.size() !== 4) begin n_err++; $display("FAIL b2b_count got %0d want 4", got.size()); end
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== exp[i]) begin n_err++; $display("FAIL b2b_result[%0d] got %0d want %0d", i, got[i], exp[i]); end
      end
      n_cmp++; if (ops_cnt !== 16'd4) begin n_err++; $display("FAIL b2b_ops_cnt got %0d want 4", ops_cnt); end
   endtask

   task automatic test_reset_inflight;
      @(negedge clk);
      out_ready = 1'b1; op_in = ADD; a_in = 6'd7; b_in = 6'd8; in_valid = 1'b1;
      @(negedge clk);
      op_in = SUB; a_in = 6'd20; b_in = 6'd3;
      @(negedge clk);
      in_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstfl_out_valid got %b want 0", out_valid); end
      n_cmp++; if (out !== 7'd0) begin n_err++; $display("FAIL rstfl_out got %0d want 0", out); end
      n_cmp++; if (ops_cnt !== 16'd0) begin n_err++; $display("FAIL rstfl_ops_cnt got %0d want 0", ops_cnt); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstfl_in_ready got %b want 1", in_ready); end
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstfl_stale cyc %0d out_valid got %b want 0", k, out_valid); end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_logic();
      test_shift();
      test_mul();
      test_back_to_back();
      test_reset_inflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
